// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and the datapath mux selects.
package rv_ctrl_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned WD_W  = 8;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_ADDI  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_PC   = 2'b01,
        SRC_A_ZERO = 2'b10
    } alu_src_a_t;

    // One-hot instruction class
    typedef struct packed {
        logic r;
        logic load;
        logic op_imm;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } cls_t;

    localparam cls_t CLS_RESET = cls_t'(9'b1_0000_0000);

endpackage

// File: rtl/ctrl_decode.sv
// Opcode/funct3 to one-hot instruction class.
//   opcode_i  : IR[6:0]
//   funct3_i  : IR[14:12]
//   cls_o     : one-hot class
//   imm_add_o : funct3 == 000 (OP-IMM is a plain ADDI)
//   illegal_o : opcode not in the supported set
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [F3_W-1:0]  funct3_i,
    output cls_t             cls_o,
    output logic             imm_add_o,
    output logic             illegal_o
);

    always_comb begin
        cls_o     = '0;
        illegal_o = 1'b0;
        imm_add_o = (funct3_i == F3_W'(0));
        case (opcode_i)
            OPC_R:      cls_o.r      = 1'b1;
            OPC_LOAD:   cls_o.load   = 1'b1;
            OPC_OP_IMM: cls_o.op_imm = 1'b1;
            OPC_STORE:  cls_o.store  = 1'b1;
            OPC_BRANCH: cls_o.branch = 1'b1;
            OPC_JAL:    cls_o.jal    = 1'b1;
            OPC_JALR:   cls_o.jalr   = 1'b1;
            OPC_LUI:    cls_o.lui    = 1'b1;
            OPC_AUIPC:  cls_o.auipc  = 1'b1;
            default:    illegal_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: FETCH/DECODE/EXEC/MEM/WB with a
// memory watchdog and sticky TRAP. Outputs are decoded from the state, the
// registered class, br_taken and mem_ready; all are forced low during reset.
//   clk, rst (async, active-high)
//   opcode, funct3, mem_ready, br_taken         : inputs
//   mem_req, mem_we, mem_addr_sel, ir_we, pc_we : memory / PC / IR enables
//   pc_src, alu_op, alu_src_a, alu_src_b        : datapath selects
//   reg_we, wb_sel, instr_done, trap            : writeback / status
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             instr_done,
    output logic             trap
);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic             addi_q, addi_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    cls_t dec_cls;
    logic dec_addi;
    logic dec_illegal;

    ctrl_decode u_decode (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .cls_o     (dec_cls),
        .imm_add_o (dec_addi),
        .illegal_o (dec_illegal)
    );

    // State, class and watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_RESET;
            addi_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            addi_q  <= addi_d;
            wd_q    <= wd_d;
        end
    end

    logic timeout;

    // Next state and control outputs
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        addi_d       = addi_q;
        wd_d         = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        alu_op       = ALU_ADD;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        instr_done   = 1'b0;
        trap         = 1'b0;

        // The stall that would bring the count to MEM_TIMEOUT traps; a
        // same-cycle mem_ready completes the transfer instead.
        timeout = !mem_ready && (wd_q == WD_W'(MEM_TIMEOUT - 1));

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                wd_d    = mem_ready ? '0 : wd_q + WD_W'(1);
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                addi_d  = dec_addi;
                state_d = dec_illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (cls_q.r) begin
                    alu_op  = ALU_FUNCT;
                    state_d = S_WB;
                end else if (cls_q.op_imm) begin
                    alu_src_b = 1'b1;
                    alu_op    = addi_q ? ALU_ADDI : ALU_FUNCT;
                    state_d   = S_WB;
                end else if (cls_q.lui || cls_q.auipc) begin
                    alu_src_a = cls_q.lui ? SRC_A_ZERO : SRC_A_PC;
                    alu_src_b = 1'b1;
                    state_d   = S_WB;
                end else if (cls_q.load || cls_q.store) begin
                    alu_src_b = 1'b1;
                    state_d   = S_MEM;
                end else if (cls_q.branch) begin
                    alu_op     = ALU_SUB;
                    pc_we      = 1'b1;
                    pc_src     = br_taken ? PC_TARGET : PC_PLUS4;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    // JAL / JALR: link PC+4 and redirect in one cycle
                    alu_src_b  = cls_q.jalr;
                    pc_src     = cls_q.jalr ? PC_ALU : PC_TARGET;
                    pc_we      = 1'b1;
                    reg_we     = 1'b1;
                    wb_sel     = WB_PC4;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = cls_q.store;
                wd_d         = mem_ready ? '0 : wd_q + WD_W'(1);
                if (mem_ready) begin
                    if (cls_q.store) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                wb_sel     = cls_q.load ? WB_MEM : WB_ALU;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // No enable may leak while reset is held
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = PC_PLUS4;
            alu_op       = ALU_ADD;
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = 1'b0;
            reg_we       = 1'b0;
            wb_sel       = WB_ALU;
            instr_done   = 1'b0;
            trap         = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       br_taken;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0] pc_src, alu_op, alu_src_a, wb_sel;
    logic       alu_src_b, reg_we, instr_done, trap;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .instr_done   (instr_done),
        .trap         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
    // pc_src[1:0], alu_op[1:0], alu_src_a[1:0], alu_src_b, reg_we,
    // wb_sel[1:0], instr_done, trap}
    localparam logic [16:0] NONE    = 17'h00000;
    localparam logic [16:0] MREQ    = 17'h10000;
    localparam logic [16:0] MWE     = 17'h08000;
    localparam logic [16:0] MADDR   = 17'h04000;
    localparam logic [16:0] IRWE    = 17'h02000;
    localparam logic [16:0] PCWE    = 17'h01000;
    localparam logic [16:0] PCS_TGT = 17'h00400;
    localparam logic [16:0] PCS_ALU = 17'h00800;
    localparam logic [16:0] AL_SUB  = 17'h00100;
    localparam logic [16:0] AL_FN   = 17'h00200;
    localparam logic [16:0] AL_ADDI = 17'h00300;
    localparam logic [16:0] SA_PC   = 17'h00040;
    localparam logic [16:0] SA_ZERO = 17'h00080;
    localparam logic [16:0] SRCB    = 17'h00020;
    localparam logic [16:0] REGWE   = 17'h00010;
    localparam logic [16:0] WBMEM   = 17'h00004;
    localparam logic [16:0] WBPC4   = 17'h00008;
    localparam logic [16:0] DONE    = 17'h00002;
    localparam logic [16:0] TRAPB   = 17'h00001;
    localparam logic [16:0] RETIRE  = 17'h01012; // WB: pc_we | reg_we | done

    logic [16:0] act;
    assign act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_op,
                  alu_src_a, alu_src_b, reg_we, wb_sel, instr_done, trap};

    typedef struct {
        logic [16:0] exp;
        string       nm;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares whatever the DUT presents this cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            rec_t r;
            r = sb.pop_front();
            checks++;
            if (act !== r.exp) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h (t=%0t)", r.nm, act, r.exp, $time);
            end
        end
    end

    task automatic step(input logic r, input logic rdy, input logic br,
                        input logic [16:0] e, input string nm);
        rec_t rec;
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        br_taken  = br;
        rec.exp   = e;
        rec.nm    = nm;
        sb.push_back(rec);
    endtask

    // Zero-wait fetch then decode of the given instruction
    task automatic fetch_dec(input logic [6:0] op, input logic [2:0] f3, input string nm);
        opcode = op;
        funct3 = f3;
        step(1'b0, 1'b1, 1'b0, MREQ | IRWE, {nm, "_fetch"});
        step(1'b0, 1'b1, 1'b0, NONE,        {nm, "_decode"});
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'b0010011;
        funct3    = 3'b000;
        mem_ready = 1'b1;
        br_taken  = 1'b0;

        step(1'b1, 1'b1, 1'b0, NONE, "reset_hold");

        // ADDI after reset release
        fetch_dec(7'b0010011, 3'b000, "addi");
        step(1'b0, 1'b1, 1'b0, SRCB | AL_ADDI, "addi_exec");
        step(1'b0, 1'b1, 1'b0, RETIRE,         "addi_wb");

        // LOAD with two MEM wait states
        fetch_dec(7'b0000011, 3'b010, "load");
        step(1'b0, 1'b1, 1'b0, SRCB,            "load_exec");
        step(1'b0, 1'b0, 1'b0, MREQ | MADDR,    "load_mem_w1");
        step(1'b0, 1'b0, 1'b0, MREQ | MADDR,    "load_mem_w2");
        step(1'b0, 1'b1, 1'b0, MREQ | MADDR,    "load_mem_rdy");
        step(1'b0, 1'b1, 1'b0, RETIRE | WBMEM,  "load_wb");

        // R-type, ANDI, LUI, AUIPC
        fetch_dec(7'b0110011, 3'b000, "rtype");
        step(1'b0, 1'b1, 1'b0, AL_FN,           "rtype_exec");
        step(1'b0, 1'b1, 1'b0, RETIRE,          "rtype_wb");
        fetch_dec(7'b0010011, 3'b111, "andi");
        step(1'b0, 1'b1, 1'b0, SRCB | AL_FN,    "andi_exec");
        step(1'b0, 1'b1, 1'b0, RETIRE,          "andi_wb");
        fetch_dec(7'b0110111, 3'b000, "lui");
        step(1'b0, 1'b1, 1'b0, SA_ZERO | SRCB,  "lui_exec");
        step(1'b0, 1'b1, 1'b0, RETIRE,          "lui_wb");
        fetch_dec(7'b0010111, 3'b000, "auipc");
        step(1'b0, 1'b1, 1'b0, SA_PC | SRCB,    "auipc_exec");
        step(1'b0, 1'b1, 1'b0, RETIRE,          "auipc_wb");

        // STORE, zero-wait
        fetch_dec(7'b0100011, 3'b010, "store");
        step(1'b0, 1'b1, 1'b0, SRCB,                             "store_exec");
        step(1'b0, 1'b1, 1'b0, MREQ | MADDR | MWE | PCWE | DONE, "store_mem");

        // BRANCH taken, then not taken
        fetch_dec(7'b1100011, 3'b000, "beq_t");
        step(1'b0, 1'b1, 1'b1, AL_SUB | PCWE | PCS_TGT | DONE, "beq_t_exec");
        fetch_dec(7'b1100011, 3'b000, "beq_n");
        step(1'b0, 1'b1, 1'b0, AL_SUB | PCWE | DONE,           "beq_n_exec");

        // JAL, JALR
        fetch_dec(7'b1101111, 3'b000, "jal");
        step(1'b0, 1'b1, 1'b0, PCS_TGT | PCWE | REGWE | WBPC4 | DONE, "jal_exec");
        fetch_dec(7'b1100111, 3'b000, "jalr");
        step(1'b0, 1'b1, 1'b0, SRCB | PCS_ALU | PCWE | REGWE | WBPC4 | DONE, "jalr_exec");

        // Reset asserted in JAL EXEC aborts without any enable
        fetch_dec(7'b1101111, 3'b000, "jal_abort");
        step(1'b1, 1'b1, 1'b1, NONE,        "abort_rst");
        step(1'b0, 1'b1, 1'b0, MREQ | IRWE, "abort_refetch");
        step(1'b0, 1'b1, 1'b0, NONE,        "abort_decode");
        step(1'b0, 1'b1, 1'b0, PCS_TGT | PCWE | REGWE | WBPC4 | DONE, "abort_jal_exec");

        // Illegal opcode: trap for 20 cycles, cleared by reset
        fetch_dec(7'b1111111, 3'b000, "illegal");
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b1, TRAPB, "illegal_trap");
        step(1'b1, 1'b1, 1'b0, NONE,        "illegal_rst");
        step(1'b0, 1'b0, 1'b0, MREQ,        "illegal_after_rst");

        // Watchdog: ready on 15th request cycle wins (continues FETCH above)
        for (int i = 0; i < 13; i++)
            step(1'b0, 1'b0, 1'b0, MREQ, "wd_ok_wait");
        opcode = 7'b0110111;
        step(1'b0, 1'b1, 1'b0, MREQ | IRWE,    "wd_ok_ready15");
        step(1'b0, 1'b1, 1'b0, NONE,           "wd_ok_decode");
        step(1'b0, 1'b1, 1'b0, SA_ZERO | SRCB, "wd_ok_exec");
        step(1'b0, 1'b1, 1'b0, RETIRE,         "wd_ok_wb");

        // Watchdog: 15 stalled request cycles then trap
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 1'b0, MREQ, "wd_to_wait");
        step(1'b0, 1'b0, 1'b0, TRAPB, "wd_to_trap");
        step(1'b0, 1'b1, 1'b0, TRAPB, "wd_to_trap_sticky");
        step(1'b1, 1'b0, 1'b0, NONE,  "wd_to_rst");
        step(1'b0, 1'b1, 1'b0, MREQ | IRWE, "wd_to_refetch");

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
